// File: rtl/dac_vol_arbiter.sv
// dac_vol_arbiter: round-robin sharing of one dac5571_set_vol between
// NUM_REQ requesters, each owning a one-entry slot.
// Optional build macro DAC_VOL_SKIP_SAME_EN: a granted code equal to
// cur_vol completes immediately without a DAC write.

// One requester slot: holds a captured code until the arbiter frees it.
module dac_vol_slot (
   input  logic       clk,
   input  logic       rst,
   input  logic       cap,
   input  logic       free,
   input  logic [7:0] vol_in,
   output logic       full,
   output logic [7:0] vol
);
   // capture has priority; cap and free never hit the same slot together
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         vol  <= 8'h00;
      end else if (cap) begin
         full <= 1'b1;
         vol  <= vol_in;
      end else if (free) begin
         full <= 1'b0;
      end
   end
endmodule

module dac_vol_arbiter #(
   parameter int         NUM_REQ     = 3,
   parameter int         TIMEOUT_CYC = 50_000,
   parameter logic [7:0] VOL_INIT    = 8'h00
) (
   input  logic                 sclk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_vol,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   req_done,
   output logic [NUM_REQ-1:0]   req_err,
   output logic [7:0]           dac_vol,
   output logic                 dac_set_trig,
   input  logic                 dac_set_done,
   output logic                 busy,
   output logic [7:0]           cur_vol
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]                 state;
   logic [IW-1:0]              ptr;
   logic [IW-1:0]              gnt;
   logic [CW-1:0]              cnt;
   logic [NUM_REQ-1:0]         slot_full;
   logic [NUM_REQ-1:0][7:0]    slot_vol;
   logic [NUM_REQ-1:0]         free;
   logic [IW-1:0]              nxt_idx;
   logic                       any_full;
   logic                       timeout;

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] i);
      return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      dac_vol_slot u_slot (
         .clk    (sclk),
         .rst    (rst),
         .cap    (req_valid[i] & ~slot_full[i]),
         .free   (free[i]),
         .vol_in (req_vol[8*i +: 8]),
         .full   (slot_full[i]),
         .vol    (slot_vol[i])
      );
   end

   assign req_ready    = ~slot_full;
   assign dac_set_trig = (state == S_ISSUE);
   assign busy         = (state != S_IDLE);
   assign timeout      = (cnt == CW'(TIMEOUT_CYC - 1));

   // first full slot from ptr upward with wrap; scanning downward lets the
   // lowest offset win without an early exit
   always_comb begin
      int tmp;
      logic [IW-1:0] idx;
      nxt_idx  = '0;
      any_full = 1'b0;
      tmp      = 0;
      idx      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         tmp = int'(ptr) + k;
         if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
         idx = IW'(tmp);
         if (slot_full[idx]) begin
            nxt_idx  = idx;
            any_full = 1'b1;
         end
      end
   end

   // slot release, on the same edge that raises req_done/req_err
   always_comb begin
      free = '0;
      if (state == S_WAIT && (dac_set_done || timeout)) free[gnt] = 1'b1;
`ifdef DAC_VOL_SKIP_SAME_EN
      if (state == S_IDLE && any_full && slot_vol[nxt_idx] == cur_vol)
         free[nxt_idx] = 1'b1;
`endif
   end

   // scheduler FSM: IDLE -> ISSUE -> WAIT -> IDLE
   always_ff @(posedge sclk) begin
      if (rst) begin
         state    <= S_IDLE;
         ptr      <= '0;
         gnt      <= '0;
         cnt      <= '0;
         dac_vol  <= VOL_INIT;
         cur_vol  <= VOL_INIT;
         req_done <= '0;
         req_err  <= '0;
      end else begin
         req_done <= '0;
         req_err  <= '0;
         case (state)
            S_IDLE: begin
               if (any_full) begin
`ifdef DAC_VOL_SKIP_SAME_EN
                  if (slot_vol[nxt_idx] == cur_vol) begin
                     req_done[nxt_idx] <= 1'b1;
                     ptr               <= ptr_inc(nxt_idx);
                  end else begin
                     gnt     <= nxt_idx;
                     dac_vol <= slot_vol[nxt_idx];
                     state   <= S_ISSUE;
                  end
`else
                  gnt     <= nxt_idx;
                  dac_vol <= slot_vol[nxt_idx];
                  state   <= S_ISSUE;
`endif
               end
            end
            S_ISSUE: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // done wins over a simultaneous timeout
               if (dac_set_done) begin
                  cur_vol       <= dac_vol;
                  req_done[gnt] <= 1'b1;
                  ptr           <= ptr_inc(gnt);
                  state         <= S_IDLE;
               end else if (timeout) begin
                  req_err[gnt] <= 1'b1;
                  ptr          <= ptr_inc(gnt);
                  state        <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dac_vol_arbiter.sv
// Directed bench for dac_vol_arbiter (NUM_REQ=3, TIMEOUT_CYC=100).
module tb_dac_vol_arbiter;
   logic        sclk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [23:0] req_vol;
   logic [2:0]  req_ready;
   logic [2:0]  req_done;
   logic [2:0]  req_err;
   logic [7:0]  dac_vol;
   logic        dac_set_trig;
   logic        dac_set_done;
   logic        busy;
   logic [7:0]  cur_vol;

   int vec_cnt = 0;
   int err_cnt = 0;

   dac_vol_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(100), .VOL_INIT(8'h00)) dut (
      .sclk         (sclk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_vol      (req_vol),
      .req_ready    (req_ready),
      .req_done     (req_done),
      .req_err      (req_err),
      .dac_vol      (dac_vol),
      .dac_set_trig (dac_set_trig),
      .dac_set_done (dac_set_done),
      .busy         (busy),
      .cur_vol      (cur_vol)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   typedef struct {
      logic [2:0]  vld;
      logic [23:0] vol;
      logic        done;
      logic [26:0] exp;
   } vec_t;

   // {ready, done, err, trig, busy, cur_vol, dac_vol}
   function automatic logic [26:0] pk(input logic [2:0] rdy, input logic [2:0] dn,
                                      input logic [2:0] er, input logic tr, input logic bs,
                                      input logic [7:0] cv, input logic [7:0] dv);
      return {rdy, dn, er, tr, bs, cv, dv};
   endfunction

   function automatic logic [26:0] outs();
      return {req_ready, req_done, req_err, dac_set_trig, busy, cur_vol, dac_vol};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; req_vol = '0; dac_set_done = 1'b0;
      repeat (3) @(posedge sclk);
      #1 rst = 1'b0;
   endtask

   // wait (bounded) for a trigger pulse and check the presented code
   task automatic wait_trig(input logic [7:0] exp_vol, input string name);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge sclk); #1;
         if (dac_set_trig) seen = 1;
      end
      check({name, "_trig"}, 32'(seen), 32'd1);
      if (seen) check({name, "_vol"}, 32'(dac_vol), 32'(exp_vol));
   endtask

   // act as the DAC: return done after delay cycles, check the completion edge
   task automatic finish_write(input int delay, input logic [2:0] exp_done,
                               input logic [2:0] exp_rdy, input logic [7:0] exp_cur,
                               input string name);
      repeat (delay) @(posedge sclk);
      #1 dac_set_done = 1'b1;
      @(posedge sclk); #1 dac_set_done = 1'b0;
      check({name, "_done"}, 32'(req_done), 32'(exp_done));
      check({name, "_ready"}, 32'(req_ready), 32'(exp_rdy));
      check({name, "_cur"}, 32'(cur_vol), 32'(exp_cur));
   endtask

   vec_t tbl [13];

   initial begin
      int k;
      logic tr_any;
      tbl[0]  = '{3'b010, 24'h00A500, 1'b0, pk(3'b101, 3'b000, 3'b000, 0, 0, 8'h00, 8'h00)};
      tbl[1]  = '{3'b000, 24'h000000, 1'b0, pk(3'b101, 3'b000, 3'b000, 1, 1, 8'h00, 8'hA5)};
      tbl[2]  = '{3'b000, 24'h000000, 1'b1, pk(3'b101, 3'b000, 3'b000, 0, 1, 8'h00, 8'hA5)};
      tbl[3]  = '{3'b000, 24'h000000, 1'b1, pk(3'b111, 3'b010, 3'b000, 0, 0, 8'hA5, 8'hA5)};
      tbl[4]  = '{3'b001, 24'h000055, 1'b0, pk(3'b110, 3'b000, 3'b000, 0, 0, 8'hA5, 8'hA5)};
      tbl[5]  = '{3'b000, 24'h000000, 1'b1, pk(3'b110, 3'b000, 3'b000, 1, 1, 8'hA5, 8'h55)};
      tbl[6]  = '{3'b000, 24'h000000, 1'b0, pk(3'b110, 3'b000, 3'b000, 0, 1, 8'hA5, 8'h55)};
      tbl[7]  = '{3'b000, 24'h000000, 1'b0, pk(3'b110, 3'b000, 3'b000, 0, 1, 8'hA5, 8'h55)};
      tbl[8]  = '{3'b000, 24'h000000, 1'b1, pk(3'b111, 3'b001, 3'b000, 0, 0, 8'h55, 8'h55)};
      tbl[9]  = '{3'b100, 24'h070000, 1'b0, pk(3'b011, 3'b000, 3'b000, 0, 0, 8'h55, 8'h55)};
      tbl[10] = '{3'b100, 24'h080000, 1'b0, pk(3'b011, 3'b000, 3'b000, 1, 1, 8'h55, 8'h07)};
      tbl[11] = '{3'b000, 24'h000000, 1'b0, pk(3'b011, 3'b000, 3'b000, 0, 1, 8'h55, 8'h07)};
      tbl[12] = '{3'b000, 24'h000000, 1'b1, pk(3'b111, 3'b100, 3'b000, 0, 0, 8'h07, 8'h07)};

      // reset state
      do_reset();
      check("reset", 32'(outs()), 32'(pk(3'b111, 3'b000, 3'b000, 0, 0, 8'h00, 8'h00)));

      // cycle table: drive, clock, compare the post-edge outputs
      for (int i = 0; i < 13; i++) begin
         req_valid = tbl[i].vld; req_vol = tbl[i].vol; dac_set_done = tbl[i].done;
         @(posedge sclk); #1;
         vec_cnt++;
         if (outs() !== tbl[i].exp) begin
            err_cnt++;
            $display("FAIL vec%0d: got %h, want %h", i, outs(), tbl[i].exp);
         end
      end
      req_valid = '0; dac_set_done = 1'b0;

      // latency: accept at T, trig in cycle T+2, done 40 cycles later
      do_reset();
      req_valid = 3'b010; req_vol = 24'h00A500;
      @(posedge sclk); #1 req_valid = '0;
      check("lat_t1_trig", 32'(dac_set_trig), 32'd0);
      @(posedge sclk); #1;
      check("lat_t2_trig", 32'(dac_set_trig), 32'd1);
      check("lat_t2_vol", 32'(dac_vol), 32'hA5);
      finish_write(40, 3'b010, 3'b111, 8'hA5, "lat");

      // round-robin ordering with a late re-request from 0
      do_reset();
      req_valid = 3'b111; req_vol = 24'h302010;
      @(posedge sclk); #1 req_valid = '0;
      wait_trig(8'h10, "ord0");
      finish_write(3, 3'b001, 3'b001, 8'h10, "ord0");
      wait_trig(8'h20, "ord1");
      req_valid = 3'b001; req_vol = 24'h000040;
      @(posedge sclk); #1 req_valid = '0;
      finish_write(2, 3'b010, 3'b010, 8'h20, "ord1");
      wait_trig(8'h30, "ord2");
      finish_write(3, 3'b100, 3'b110, 8'h30, "ord2");
      wait_trig(8'h40, "ord3");
      finish_write(3, 3'b001, 3'b111, 8'h40, "ord3");

      // timeout: no done, err exactly 100 cycles after WAIT entry
      do_reset();
      req_valid = 3'b011; req_vol = 24'h004433;
      @(posedge sclk); #1 req_valid = '0;
      wait_trig(8'h33, "to0");
      @(posedge sclk); #1;
      k = 0;
      for (int i = 0; i < 300 && req_err == 3'b000; i++) begin
         @(posedge sclk); #1;
         k++;
      end
      check("to_cycles", 32'(k), 32'd100);
      check("to_err", 32'(req_err), 32'(3'b001));
      check("to_cur", 32'(cur_vol), 32'h00);
      check("to_ready", 32'(req_ready), 32'(3'b101));
      wait_trig(8'h44, "to1");
      finish_write(5, 3'b010, 3'b111, 8'h44, "to1");

      // reset during WAIT, then a stale done
      do_reset();
      req_valid = 3'b101; req_vol = 24'h660011;
      @(posedge sclk); #1 req_valid = '0;
      wait_trig(8'h11, "mr");
      @(posedge sclk); #1 rst = 1'b1;
      @(posedge sclk); #1 rst = 1'b0;
      check("mr_reset", 32'(outs()), 32'(pk(3'b111, 3'b000, 3'b000, 0, 0, 8'h00, 8'h00)));
      dac_set_done = 1'b1;
      @(posedge sclk); #1 dac_set_done = 1'b0;
      check("mr_late_done", 32'(outs()), 32'(pk(3'b111, 3'b000, 3'b000, 0, 0, 8'h00, 8'h00)));
      tr_any = 1'b0;
      repeat (10) begin
         @(posedge sclk); #1 tr_any = tr_any | dac_set_trig;
      end
      check("mr_no_trig", 32'(tr_any), 32'd0);

      // request equal to cur_vol right after reset
      do_reset();
      req_valid = 3'b001; req_vol = 24'h000000;
      @(posedge sclk); #1 req_valid = '0;
`ifdef DAC_VOL_SKIP_SAME_EN
      @(posedge sclk); #1;
      check("skip_done", 32'(outs()), 32'(pk(3'b111, 3'b001, 3'b000, 0, 0, 8'h00, 8'h00)));
      tr_any = 1'b0;
      repeat (5) begin
         @(posedge sclk); #1 tr_any = tr_any | dac_set_trig;
      end
      check("skip_no_trig", 32'(tr_any), 32'd0);
`else
      wait_trig(8'h00, "same");
      finish_write(2, 3'b001, 3'b111, 8'h00, "same");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
